// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: sequences one register-to-register or external-to-register
// transfer over a shared bus: DRIVE -> LATCH -> HOLD, then a done pulse.
// Optional feature: define BUS_SNOOP_EN to capture the bus value at each load
// into snoop_data; without it snoop_data is tied to zero.
module bus_transfer_ctrl #(
    parameter int  BITS  = 8,
    parameter int  NREGS = 4,
    localparam int IW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [IW-1:0]    cmd_src,
    input  logic [IW-1:0]    cmd_dst,
    input  logic             cmd_ext,
    input  logic [BITS-1:0]  ext_data,
    input  logic [BITS-1:0]  bus_in,
    output logic [NREGS-1:0] reg_en,
    output logic [NREGS-1:0] reg_set,
    output logic [BITS-1:0]  bus_out,
    output logic             ext_drive,
    output logic             done,
    output logic             err,
    output logic [BITS-1:0]  snoop_data
);

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    dst_q, dst_d;
    logic [BITS-1:0]  data_q, data_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [NREGS-1:0] reg_en_q, reg_en_d;
    logic [NREGS-1:0] reg_set_q, reg_set_d;
    logic             ext_drive_q, ext_drive_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;
    logic             cmd_bad;

    function automatic logic [NREGS-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREGS-1:0] v;
        v    = '0;
        v[0] = 1'b1;
        return v << idx;
    endfunction

    // Command handshake and legality of the offered command.
    always_comb begin
        accept  = cmd_valid && cmd_ready_q && (state_q == IDLE);
        cmd_bad = (32'(cmd_dst) >= 32'(NREGS)) ||
                  (!cmd_ext && ((32'(cmd_src) >= 32'(NREGS)) || (cmd_src == cmd_dst)));
    end

    // Next-state and next-output logic; all outputs are registered from these.
    // The source select is held in reg_en_q/ext_drive_q from acceptance onward,
    // so the source index itself need not be kept in a separate register.
    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        data_d      = data_q;
        reg_en_d    = '0;
        reg_set_d   = '0;
        ext_drive_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dst_d  = cmd_dst;
                    data_d = ext_data;
                    if (cmd_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = DRIVE;
                        if (cmd_ext) ext_drive_d = 1'b1;
                        else         reg_en_d    = onehot(cmd_src);
                    end
                end
            end
            DRIVE: begin
                state_d     = LATCH;
                reg_en_d    = reg_en_q;
                ext_drive_d = ext_drive_q;
                reg_set_d   = onehot(dst_q);
            end
            LATCH: begin
                state_d     = HOLD;
                reg_en_d    = reg_en_q;
                ext_drive_d = ext_drive_q;
            end
            HOLD: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    // State and registered outputs; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dst_q       <= '0;
            data_q      <= '0;
            cmd_ready_q <= 1'b0;
            reg_en_q    <= '0;
            reg_set_q   <= '0;
            ext_drive_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            cmd_ready_q <= cmd_ready_d;
            reg_en_q    <= reg_en_d;
            reg_set_q   <= reg_set_d;
            ext_drive_q <= ext_drive_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef BUS_SNOOP_EN
    logic [BITS-1:0] snoop_q, snoop_d;

    // Capture the bus on the edge that ends LATCH (the edge that drops reg_set).
    always_comb begin
        snoop_d = (state_q == LATCH) ? bus_in : snoop_q;
    end

    // Snoop register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) snoop_q <= '0;
        else     snoop_q <= snoop_d;
    end

    assign snoop_data = snoop_q;
`else
    logic unused_bus_in;
    assign unused_bus_in = ^bus_in;
    assign snoop_data    = '0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign reg_en    = reg_en_q;
    assign reg_set   = reg_set_q;
    assign ext_drive = ext_drive_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bus_out   = ext_drive_q ? data_q : 'z;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Self-checking bench for bus_transfer_ctrl with a behavioural model of the
// four bus registers and a scoreboard of expected transfer results.
module tb_bus_transfer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_src;
    logic [1:0] cmd_dst;
    logic       cmd_ext;
    logic [7:0] ext_data;
    logic [7:0] bus_in;
    logic [3:0] reg_en;
    logic [3:0] reg_set;
    wire  [7:0] bus_out;
    logic       ext_drive;
    logic       done;
    logic       err;
    logic [7:0] snoop_data;

    bus_transfer_ctrl #(.BITS(8), .NREGS(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_ext(cmd_ext),
        .ext_data(ext_data), .bus_in(bus_in), .reg_en(reg_en),
        .reg_set(reg_set), .bus_out(bus_out), .ext_drive(ext_drive),
        .done(done), .err(err), .snoop_data(snoop_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [1:0] dst;
        logic [7:0] val;
        logic [7:0] snoop;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] regs[4];
    logic [3:0] set_prev = '0;
    logic [7:0] snoop_exp = '0;
    int         tests = 0;
    int         fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Shared bus as seen by the registers and by the controller's bus_in.
    always_comb begin
        bus_in = '0;
        if (ext_drive) bus_in = bus_out;
        else begin
            for (int i = 0; i < 4; i++)
                if (reg_en[i]) bus_in = regs[i];
        end
    end

    // Register model loads, driver exclusivity, and scoreboard checks on done.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            check_eq("one_driver", 32'(($countones(reg_en) + 32'(ext_drive)) <= 1), 32'(1));
            for (int i = 0; i < 4; i++)
                if (reg_set[i] && !set_prev[i]) regs[i] = bus_in;
            set_prev = reg_set;
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("done_unexpected", 32'(done), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check_eq("sb_err", 32'(err), 32'(e.err));
                    if (!e.err) check_eq("sb_dst_val", 32'(regs[e.dst]), 32'(e.val));
                    check_eq("sb_snoop", 32'(snoop_data), 32'(e.snoop));
                end
            end
        end else begin
            set_prev = '0;
        end
    end

    task automatic push_exp(input logic e, input logic [1:0] dst, input logic [7:0] val);
`ifdef BUS_SNOOP_EN
        if (!e) snoop_exp = val;
`endif
        sb.push_back('{err: e, dst: dst, val: val, snoop: snoop_exp});
    endtask

    task automatic drive_cmd(input logic [1:0] src, input logic [1:0] dst,
                             input logic ext, input logic [7:0] data);
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_ext   = ext;
        ext_data  = data;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", 32'(n < 20), 32'(1));
    endtask

    // Checks the DRIVE, LATCH, HOLD cycles and the done cycle of a valid transfer.
    task automatic check_phases(input logic [3:0] en_e, input logic ext,
                                input logic [7:0] data, input logic [3:0] set_e);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c < 4) begin
                check_eq($sformatf("reg_en_c%0d", c), 32'(reg_en), 32'(en_e));
                check_eq($sformatf("ext_drive_c%0d", c), 32'(ext_drive), 32'(ext));
                check_eq($sformatf("reg_set_c%0d", c), 32'(reg_set), 32'((c == 2) ? set_e : 4'b0000));
                check_eq($sformatf("done_c%0d", c), 32'(done), 32'(0));
                check_eq($sformatf("ready_c%0d", c), 32'(cmd_ready), 32'(0));
                if (ext) check_eq($sformatf("bus_out_c%0d", c), 32'(bus_out), 32'(data));
            end else begin
                check_eq("done_c4", 32'(done), 32'(1));
                check_eq("err_c4", 32'(err), 32'(0));
                check_eq("reg_en_c4", 32'(reg_en), 32'(0));
                check_eq("ext_drive_c4", 32'(ext_drive), 32'(0));
                check_eq("ready_c4", 32'(cmd_ready), 32'(1));
            end
        end
    endtask

    task automatic run_cmd(input logic [1:0] src, input logic [1:0] dst, input logic ext,
                           input logic [7:0] data, input logic exp_err);
        logic [3:0] en_e;
        logic [3:0] set_e;
        en_e  = ext ? 4'b0000 : (4'b0001 << src);
        set_e = 4'b0001 << dst;
        @(negedge clk);
        push_exp(exp_err, dst, ext ? data : regs[src]);
        drive_cmd(src, dst, ext, data);
        wait_ready();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_src   = ~src;
        cmd_dst   = ~dst;
        cmd_ext   = ~ext;
        ext_data  = ~data;
        if (exp_err) begin
            @(negedge clk);
            check_eq("rej_done", 32'(done), 32'(1));
            check_eq("rej_err", 32'(err), 32'(1));
            check_eq("rej_reg_en", 32'(reg_en), 32'(0));
            check_eq("rej_reg_set", 32'(reg_set), 32'(0));
            check_eq("rej_ext_drive", 32'(ext_drive), 32'(0));
            check_eq("rej_ready", 32'(cmd_ready), 32'(1));
        end else begin
            check_phases(en_e, ext, data, set_e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        regs      = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_ext   = 1'b0;
        ext_data  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(cmd_ready), 32'(0));
        check_eq("rst_reg_en", 32'(reg_en), 32'(0));
        check_eq("rst_reg_set", 32'(reg_set), 32'(0));
        check_eq("rst_ext_drive", 32'(ext_drive), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_err", 32'(err), 32'(0));
        check_eq("rst_snoop", 32'(snoop_data), 32'(0));
        rst = 1'b0;
        #1;
        check_eq("ready_before_edge", 32'(cmd_ready), 32'(0));
        @(negedge clk);
        check_eq("ready_after_edge", 32'(cmd_ready), 32'(1));

        run_cmd(2'd0, 2'd2, 1'b1, 8'hA5, 1'b0);   // external write A5 -> reg2
        run_cmd(2'd2, 2'd0, 1'b0, 8'h00, 1'b0);   // copy reg2 -> reg0
        run_cmd(2'd1, 2'd1, 1'b0, 8'h00, 1'b1);   // src == dst: rejected
        run_cmd(2'd1, 2'd1, 1'b1, 8'h5A, 1'b0);   // external: src ignored
        run_cmd(2'd3, 2'd3, 1'b0, 8'h00, 1'b1);   // src == dst: rejected
        run_cmd(2'd0, 2'd3, 1'b0, 8'h00, 1'b0);   // copy reg0 -> reg3

        // Back-to-back: valid held, second command accepted in the done cycle.
        @(negedge clk);
        push_exp(1'b0, 2'd1, regs[3]);
        push_exp(1'b0, 2'd3, 8'h77);
        drive_cmd(2'd3, 2'd1, 1'b0, 8'h00);
        wait_ready();
        @(posedge clk);
        #1;
        drive_cmd(2'd0, 2'd3, 1'b1, 8'h77);
        check_phases(4'b1000, 1'b0, 8'h00, 4'b0010);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_phases(4'b0000, 1'b1, 8'h77, 4'b1000);

        // Reset asserted during LATCH aborts the transfer without a done.
        @(negedge clk);
        drive_cmd(2'd0, 2'd3, 1'b1, 8'h3C);
        wait_ready();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("abort_drive", 32'(ext_drive), 32'(1));
        @(negedge clk);
        check_eq("abort_latch_set", 32'(reg_set), 32'(4'b1000));
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_reg_set", 32'(reg_set), 32'(0));
        check_eq("abort_reg_en", 32'(reg_en), 32'(0));
        check_eq("abort_ext_drive", 32'(ext_drive), 32'(0));
        check_eq("abort_ready", 32'(cmd_ready), 32'(0));
        check_eq("abort_snoop", 32'(snoop_data), 32'(0));
        snoop_exp = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rel_ready_low", 32'(cmd_ready), 32'(0));
        @(negedge clk);
        check_eq("rel_ready_high", 32'(cmd_ready), 32'(1));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 32'(0));
        end

        run_cmd(2'd1, 2'd2, 1'b0, 8'h00, 1'b0);   // copy reg1 -> reg2 after reset

        repeat (2) @(negedge clk);
        check_eq("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_transfer_ctrl.md
BUS_TRANSFER_CTRL -- requirements
Module: bus_transfer_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, data bus width.
REQ-002 SHALL have parameter NREGS, default 4, number of bus registers controlled; IW = max(1, clog2(NREGS)).
REQ-003 SHALL have clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have cmd_valid  input  1  transfer command present.
REQ-006 SHALL have cmd_ready  output  1  controller can accept a command.
REQ-007 SHALL have cmd_src  input  IW  source register index; ignored when cmd_ext=1.
REQ-008 SHALL have cmd_dst  input  IW  destination register index.
REQ-009 SHALL have cmd_ext  input  1  source is ext_data instead of a register.
REQ-010 SHALL have ext_data  input  BITS  external write data.
REQ-011 SHALL have bus_in  input  BITS  shared bus value read back.
REQ-012 SHALL have reg_en  output  NREGS  one-hot register output enables.
REQ-013 SHALL have reg_set  output  NREGS  one-hot register load strobes (rising edge loads).
REQ-014 SHALL have bus_out  output  BITS  bus drive value; high-impedance unless ext_drive=1.
REQ-015 SHALL have ext_drive  output  1  controller drives bus_out.
REQ-016 SHALL have done  output  1  one-cycle completion pulse.
REQ-017 SHALL have err  output  1  one-cycle pulse, with done, for rejected command.
REQ-018 SHALL have snoop_data  output  BITS  bus value captured at load.

Function
REQ-019 SHALL implement states IDLE, DRIVE, LATCH, HOLD.
REQ-020 SHALL assert cmd_ready only in IDLE; command accepted on cmd_valid & cmd_ready, fields registered at acceptance.
REQ-021 SHALL reject a command (IDLE->IDLE, done=err=1 next cycle, no reg_en/reg_set/ext_drive activity) when cmd_dst>=NREGS, or cmd_ext=0 and (cmd_src>=NREGS or cmd_src==cmd_dst).
REQ-022 SHALL, for a valid command, go IDLE->DRIVE->LATCH->HOLD->IDLE, one cycle each.
REQ-023 SHALL, in DRIVE, LATCH, HOLD, assert reg_en[src] (cmd_ext=0) or ext_drive with bus_out=ext_data captured at accept (cmd_ext=1); exactly one bus driver at a time.
REQ-024 SHALL assert reg_set[dst] only in LATCH; reg_set registered, glitch-free, zero in all other states.
REQ-025 SHALL pulse done=1, err=0 in the cycle after HOLD (back in IDLE); accepted-to-done latency 4 cycles.
REQ-026 SHALL allow a new command to be accepted in the same cycle done pulses.
REQ-027 SHALL hold all enables/strobes zero and bus_out high-impedance in IDLE.
REQ-028 SHALL ignore cmd_* changes while not in IDLE.

Reset
REQ-029 SHALL, on rst asserted at any time including mid-transfer, immediately force state IDLE, reg_en=0, reg_set=0, ext_drive=0, bus_out=Z, done=0, err=0, snoop_data=0, cmd_ready=0 while rst=1.
REQ-030 SHALL raise cmd_ready on first clk edge after rst deasserts; aborted transfer is not completed and produces no done.

Configuration
REQ-031 SHALL, with macro BUS_SNOOP_EN defined, load snoop_data from bus_in on the clk edge ending LATCH for every valid transfer, holding it otherwise.
REQ-032 SHALL, without BUS_SNOOP_EN, tie snoop_data to 0 and include no snoop register.

Verification
REQ-033 SHALL cover ext write: cmd_ext=1, ext_data=8'hA5, dst=2 -> ext_drive 3 cycles, reg_set=4'b0100 one cycle (LATCH), done 4 cycles after accept, reg2 reads A5.
REQ-034 SHALL cover reg copy: src=2, dst=0 -> reg_en=4'b0100 for 3 cycles, reg_set=4'b0001 in middle cycle, snoop_data=8'hA5 (BUS_SNOOP_EN), done pulse.
REQ-035 SHALL cover rejection: src=1, dst=1 -> done=err=1 next cycle, reg_en/reg_set stay 0.
REQ-036 SHALL cover back-to-back: cmd_valid held with two commands -> second accepted in done cycle, no idle gap, no overlapping drivers.
REQ-037 SHALL cover reset in LATCH: rst pulse -> reg_set, reg_en, ext_drive drop asynchronously, no done, cmd_ready returns after release.
